// File: rtl/next_pc_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit saturating counters, EX-stage training and redirect.
// Optional gshare indexing with a non-speculative global history register is enabled by GSHARE_EN.
module next_pc_predictor #(
  parameter int IDX_BITS  = 5,
  parameter int HIST_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          current_pc,
  output logic [31:0]          next_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 ex_update,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic [HIST_BITS-1:0] ex_hist,
  input  logic                 ex_mispredict,
  input  logic [31:0]          ex_correct_pc,
  output logic                 pc_redirect
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] p_idx;
  logic [IDX_BITS-1:0] u_idx;
  logic                p_hit;
  logic                u_hit;
  logic                wr_en;
  logic                wr_alloc;
  logic [1:0]          ctr_d;

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] bhr_q;
  logic [HIST_BITS-1:0] bhr_d;
  logic                 unused_bits;

  assign p_idx       = current_pc[IDX_BITS+1:2] ^ IDX_BITS'(bhr_q);
  assign u_idx       = ex_pc[IDX_BITS+1:2] ^ IDX_BITS'(ex_hist);
  assign pred_hist   = bhr_q;
  assign unused_bits = ^ex_pc[1:0];

  // History follows resolved outcomes only, so it never needs repair on a mispredict.
  always_comb begin
    bhr_d = bhr_q;
    if (ex_update) bhr_d = {bhr_q[HIST_BITS-2:0], ex_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) bhr_q <= '0;
    else       bhr_q <= bhr_d;
  end
`else
  logic unused_bits;

  assign p_idx       = current_pc[IDX_BITS+1:2];
  assign u_idx       = ex_pc[IDX_BITS+1:2];
  assign pred_hist   = '0;
  assign unused_bits = ^{ex_hist, ex_pc[1:0]};
`endif

  assign p_hit       = valid_q[p_idx] && (tag_q[p_idx] == current_pc[31:IDX_BITS+2]);
  assign pred_taken  = p_hit & ctr_q[p_idx][1];
  assign pc_redirect = ex_mispredict;

  always_comb begin
    if (ex_mispredict)   next_pc = ex_correct_pc;
    else if (pred_taken) next_pc = target_q[p_idx];
    else                 next_pc = current_pc + 32'd4;
  end

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == ex_pc[31:IDX_BITS+2]);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a latched value.
  always_comb begin
    wr_en    = 1'b0;
    wr_alloc = 1'b0;
    ctr_d    = ctr_q[u_idx];
    if (ex_update) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (ex_taken) ctr_d = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
        else          ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
      end else if (ex_taken) begin
        wr_en    = 1'b1;
        wr_alloc = 1'b1;
        ctr_d    = 2'b10;
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every read in this cycle sees pre-edge contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_en) begin
      ctr_q[u_idx] <= ctr_d;
      if (wr_alloc) valid_q[u_idx] <= 1'b1;
    end
  end

  // NOTE: tag and target are qualified by valid, so this storage has no reset and can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && ex_taken) begin
      target_q[u_idx] <= ex_target;
      tag_q[u_idx]    <= ex_pc[31:IDX_BITS+2];
    end
  end

endmodule
